// File: rtl/vga_framebuffer_pkg.sv
// Shared types and constants for the VGA framebuffer: FSM states, 3:3:3 colour
// and the default border colour.
package vga_framebuffer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } fb_state_e;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [2:0] b;
    } rgb333_t;

    localparam logic [8:0] BORDER_RGB_DEFAULT = 9'b011_011_101;

    // top3 = bits [3:1] of the palette index normalised to 4 bits; each bit turns a channel fully on.
    function automatic rgb333_t pal_default(input logic [2:0] top3);
        rgb333_t c;
        c.r = {3{top3[2]}};
        c.g = {3{top3[1]}};
        c.b = {3{top3[0]}};
        return c;
    endfunction

endpackage

// File: rtl/vga_framebuffer_fb_ram.sv
// Simple dual-port pixel store: one write port, one registered read port.
// Reads of an address being written in the same cycle return the old contents.
module fb_ram
    import vga_framebuffer_pkg::*;
#(
    parameter int AW = 14,
    parameter int DW = 4
) (
    input  logic          i_Clk,
    input  logic          i_We,
    input  logic [AW-1:0] i_Waddr,
    input  logic [DW-1:0] i_Wdata,
    input  logic [AW-1:0] i_Raddr,
    output logic [DW-1:0] o_Rdata
);

    logic [DW-1:0] mem_q [2**AW];

    always_ff @(posedge i_Clk) begin
        if (i_We) begin
            mem_q[i_Waddr] <= i_Wdata;
        end
        o_Rdata <= mem_q[i_Raddr];
    end

endmodule

// File: rtl/vga_framebuffer.sv
// Palette-indexed framebuffer scanned out against external VGA timing, with a
// write port (explicit or auto-increment address) and a background clear engine.
module vga_framebuffer
    import vga_framebuffer_pkg::*;
#(
    parameter int         FB_W       = 128,
    parameter int         FB_H       = 128,
    parameter int         BPP        = 4,
    parameter int         SCALE_LOG2 = 0,
    parameter logic [8:0] BORDER_RGB = BORDER_RGB_DEFAULT
) (
    input  logic                          i_Clk,
    input  logic                          i_Reset,
    input  logic                          i_Active,
    input  logic [9:0]                    i_Row,
    input  logic [9:0]                    i_Col,
    input  logic                          i_HSync,
    input  logic                          i_VSync,
    input  logic                          i_Wr_Valid,
    output logic                          o_Wr_Ready,
    input  logic                          i_Wr_Auto,
    input  logic [$clog2(FB_W*FB_H)-1:0]  i_Wr_Addr,
    input  logic [BPP-1:0]                i_Wr_Data,
    input  logic                          i_Ptr_Load,
    input  logic                          i_Clear,
    output logic                          o_Busy,
    input  logic                          i_Pal_We,
    input  logic [BPP-1:0]                i_Pal_Idx,
    input  logic [8:0]                    i_Pal_Data,
    output logic                          o_HSync,
    output logic                          o_VSync,
    output logic [2:0]                    o_Red,
    output logic [2:0]                    o_Grn,
    output logic [2:0]                    o_Blu
);

    localparam int              XW        = $clog2(FB_W);
    localparam int              YW        = $clog2(FB_H);
    localparam int              AW        = XW + YW;
    localparam int              NPAL      = 1 << BPP;
    localparam logic [AW-1:0]   LAST_ADDR = AW'(FB_W * FB_H - 1);
    localparam logic [10:0]     WIN_H     = 11'(FB_H << SCALE_LOG2);
    localparam logic [10:0]     WIN_W     = 11'(FB_W << SCALE_LOG2);

    fb_state_e     state_q;
    logic [AW-1:0] clr_addr_q;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          wr_ready_q, busy_q;
    logic          wr_acc;

    logic           ram_we;
    logic [AW-1:0]  ram_waddr, ram_raddr;
    logic [BPP-1:0] ram_wdata;
    logic [BPP-1:0] pix_p1;

    logic    win_p1_q, act_p1_q, hs_p1_q, vs_p1_q;
    logic    hs_q, vs_q;
    rgb333_t pal_q [NPAL];
    rgb333_t rgb_q, rgb_d;

    assign wr_acc = i_Wr_Valid && wr_ready_q;

    // The clear engine owns the write port while it runs.
    always_comb begin
        ram_we    = wr_acc;
        ram_waddr = i_Wr_Auto ? ptr_q : i_Wr_Addr;
        ram_wdata = i_Wr_Data;
        if (state_q == ST_CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = clr_addr_q;
            ram_wdata = '0;
        end
    end

    assign ram_raddr = {YW'(i_Row >> SCALE_LOG2), XW'(i_Col >> SCALE_LOG2)};

    // A pointer load wins over the post-increment of a coincident auto write.
    always_comb begin
        ptr_d = ptr_q;
        if (i_Ptr_Load) begin
            ptr_d = i_Wr_Addr;
        end else if (wr_acc && i_Wr_Auto) begin
            ptr_d = ptr_q + AW'(1);
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q    <= ST_IDLE;
            clr_addr_q <= '0;
            ptr_q      <= '0;
            wr_ready_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            case (state_q)
                ST_IDLE: begin
                    if (i_Clear) begin
                        state_q    <= ST_CLEAR;
                        clr_addr_q <= '0;
                        wr_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end else begin
                        wr_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    if (clr_addr_q == LAST_ADDR) begin
                        state_q    <= ST_IDLE;
                        wr_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                    end else begin
                        clr_addr_q <= clr_addr_q + AW'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            for (int i = 0; i < NPAL; i++) begin
                pal_q[i] <= pal_default(3'((i << (4 - BPP)) >> 1));
            end
        end else if (i_Pal_We) begin
            pal_q[i_Pal_Idx] <= rgb333_t'(i_Pal_Data);
        end
    end

    fb_ram #(
        .AW (AW),
        .DW (BPP)
    ) u_fb_ram (
        .i_Clk   (i_Clk),
        .i_We    (ram_we),
        .i_Waddr (ram_waddr),
        .i_Wdata (ram_wdata),
        .i_Raddr (ram_raddr),
        .o_Rdata (pix_p1)
    );

    // Stage 1: pixel index in flight from the RAM; qualifiers and syncs follow it.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            win_p1_q <= 1'b0;
            act_p1_q <= 1'b0;
            hs_p1_q  <= 1'b0;
            vs_p1_q  <= 1'b0;
        end else begin
            win_p1_q <= ({1'b0, i_Row} < WIN_H) && ({1'b0, i_Col} < WIN_W);
            act_p1_q <= i_Active;
            hs_p1_q  <= i_HSync;
            vs_p1_q  <= i_VSync;
        end
    end

    always_comb begin
        rgb_d = '0;
        if (act_p1_q) begin
            rgb_d = win_p1_q ? pal_q[pix_p1] : rgb333_t'(BORDER_RGB);
        end
    end

    // Stage 2: palette lookup into the output registers.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            rgb_q <= '0;
            hs_q  <= 1'b0;
            vs_q  <= 1'b0;
        end else begin
            rgb_q <= rgb_d;
            hs_q  <= hs_p1_q;
            vs_q  <= vs_p1_q;
        end
    end

    assign o_Wr_Ready = wr_ready_q;
    assign o_Busy     = busy_q;
    assign o_HSync    = hs_q;
    assign o_VSync    = vs_q;
    assign o_Red      = rgb_q.r;
    assign o_Grn      = rgb_q.g;
    assign o_Blu      = rgb_q.b;

endmodule

// File: tb/tb_vga_framebuffer.sv
// Self-checking bench for vga_framebuffer: a default instance and a 2x-scaled
// instance share all inputs and are compared against a framebuffer/palette model.
module tb_vga_framebuffer;

    localparam int         N      = 16384;
    localparam logic [8:0] BORDER = 9'b011_011_101;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, act, hs, vs, wv, wauto, pload, clr, pwe;
    logic [9:0]  row, col;
    logic [13:0] waddr;
    logic [3:0]  wdata, pidx;
    logic [8:0]  pdata;

    logic       rdy0, busy0, hso0, vso0;
    logic [2:0] r0, g0, b0;
    logic       rdy1, busy1, hso1, vso1;
    logic [2:0] r1, g1, b1;

    int checks = 0;
    int errors = 0;

    logic [3:0] fbm  [N];
    logic [8:0] palm [16];
    int         ptrm;

    vga_framebuffer dut (
        .i_Clk(clk), .i_Reset(rst), .i_Active(act), .i_Row(row), .i_Col(col),
        .i_HSync(hs), .i_VSync(vs), .i_Wr_Valid(wv), .o_Wr_Ready(rdy0),
        .i_Wr_Auto(wauto), .i_Wr_Addr(waddr), .i_Wr_Data(wdata), .i_Ptr_Load(pload),
        .i_Clear(clr), .o_Busy(busy0), .i_Pal_We(pwe), .i_Pal_Idx(pidx),
        .i_Pal_Data(pdata), .o_HSync(hso0), .o_VSync(vso0),
        .o_Red(r0), .o_Grn(g0), .o_Blu(b0)
    );

    vga_framebuffer #(.SCALE_LOG2(1)) dut_s (
        .i_Clk(clk), .i_Reset(rst), .i_Active(act), .i_Row(row), .i_Col(col),
        .i_HSync(hs), .i_VSync(vs), .i_Wr_Valid(wv), .o_Wr_Ready(rdy1),
        .i_Wr_Auto(wauto), .i_Wr_Addr(waddr), .i_Wr_Data(wdata), .i_Ptr_Load(pload),
        .i_Clear(clr), .o_Busy(busy1), .i_Pal_We(pwe), .i_Pal_Idx(pidx),
        .i_Pal_Data(pdata), .o_HSync(hso1), .o_VSync(vso1),
        .o_Red(r1), .o_Grn(g1), .o_Blu(b1)
    );

    initial begin
        #(10 * 200000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic logic [8:0] pal_reset_val(input int i);
        return {((i & 8) != 0) ? 3'd7 : 3'd0,
                ((i & 4) != 0) ? 3'd7 : 3'd0,
                ((i & 2) != 0) ? 3'd7 : 3'd0};
    endfunction

    function automatic logic [8:0] model_rgb(input logic a, input int r, input int c, input int sl);
        if (!a) return 9'd0;
        if (r >= (128 << sl) || c >= (128 << sl)) return BORDER;
        return palm[fbm[(r >> sl) * 128 + (c >> sl)]];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) palm[i] = pal_reset_val(i);
        ptrm = 0;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        act = 0; row = '0; col = '0; hs = 0; vs = 0;
        wv = 0; wauto = 0; waddr = '0; wdata = '0; pload = 0;
        clr = 0; pwe = 0; pidx = '0; pdata = '0;
    endtask

    task automatic do_write(input logic auto, input int addr, input logic [3:0] d);
        wv = 1; wauto = auto; waddr = 14'(addr); wdata = d;
        tick();
        wv = 0; wauto = 0;
        if (auto) begin
            fbm[ptrm] = d;
            ptrm = (ptrm + 1) % N;
        end else begin
            fbm[addr] = d;
        end
    endtask

    task automatic pal_write(input int idx, input logic [8:0] d);
        pwe = 1; pidx = 4'(idx); pdata = d;
        tick();
        pwe = 0;
        palm[idx] = d;
    endtask

    task automatic show(input logic a, input int r, input int c);
        act = a; row = 10'(r); col = 10'(c);
        tick();
        tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_inputs();
        rst = 1; hs = 1; vs = 1;
        repeat (3) tick();
        checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", rdy0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy0); end
        checks++; if ({r0, g0, b0} !== 9'd0) begin errors++; $display("FAIL reset_rgb: got %h want 0", {r0, g0, b0}); end
        checks++; if ({hso0, vso0} !== 2'b00) begin errors++; $display("FAIL reset_sync: got %b want 00", {hso0, vso0}); end
        rst = 0; hs = 0; vs = 0;
        tick();
        checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL release_ready: got %b want 1", rdy0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL release_busy: got %b want 0", busy0); end
        model_reset();
    endtask

    task automatic test_clear();
        int cnt;
        for (int k = 0; k < 8; k++) do_write(0, int'($urandom_range(0, N - 1)), 4'($urandom_range(1, 15)));
        clr = 1; wv = 1; wauto = 0; waddr = 14'd777; wdata = 4'd9;
        tick();
        clr = 0; wv = 0;
        cnt = 0;
        while (busy0 === 1'b1 && cnt < 20000) begin
            checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL clear_ready_low: got %b want 0 at %0d", rdy0, cnt); end
            clr = (cnt == 100);
            wv = (cnt >= 10 && cnt < 20); wauto = wv; wdata = 4'd5;
            pwe = (cnt == 50); pidx = 4'd0; pdata = 9'b001_010_011;
            cnt++;
            tick();
        end
        clr = 0; wv = 0; wauto = 0; pwe = 0;
        checks++; if (cnt != N) begin errors++; $display("FAIL clear_busy_len: got %0d want %0d", cnt, N); end
        checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL clear_ready_after: got %b want 1", rdy0); end
        for (int i = 0; i < N; i++) fbm[i] = 4'd0;
        palm[0] = 9'b001_010_011;
    endtask

    task automatic test_readback_all();
        logic [8:0] q0[$], q1[$];
        logic [8:0] e0, e1;
        for (int p = 0; p < N + 2; p++) begin
            if (p >= 2) begin
                e0 = q0.pop_front();
                e1 = q1.pop_front();
                checks++; if ({r0, g0, b0} !== e0) begin errors++; $display("FAIL readback px%0d: got %h want %h", p - 2, {r0, g0, b0}, e0); end
                checks++; if ({r1, g1, b1} !== e1) begin errors++; $display("FAIL readback_scaled px%0d: got %h want %h", p - 2, {r1, g1, b1}, e1); end
            end
            if (p < N) begin
                act = 1; row = 10'(p / 128); col = 10'(p % 128);
                q0.push_back(model_rgb(1'b1, p / 128, p % 128, 0));
                q1.push_back(model_rgb(1'b1, p / 128, p % 128, 1));
            end else begin
                act = 0;
            end
            tick();
        end
    endtask

    task automatic test_pixel_basic();
        logic [8:0] es;
        do_write(0, 50 * 128 + 50, 4'd15);
        es = model_rgb(1'b1, 50, 50, 1);
        act = 0; hs = 0; vs = 0;
        tick();
        act = 1; row = 10'd50; col = 10'd50; hs = 1; vs = 1;
        tick();
        checks++; if (hso0 !== 1'b0) begin errors++; $display("FAIL sync_early: got %b want 0", hso0); end
        act = 0; row = '0; col = '0; hs = 0; vs = 0;
        tick();
        checks++; if ({r0, g0, b0} !== 9'b111_111_111) begin errors++; $display("FAIL pixel_50_50: got %h want 1ff", {r0, g0, b0}); end
        checks++; if ({hso0, vso0} !== 2'b11) begin errors++; $display("FAIL sync_aligned: got %b want 11", {hso0, vso0}); end
        checks++; if ({r1, g1, b1} !== es) begin errors++; $display("FAIL pixel_scaled_50_50: got %h want %h", {r1, g1, b1}, es); end
        checks++; if (hso1 !== 1'b1) begin errors++; $display("FAIL sync_scaled: got %b want 1", hso1); end
        tick();
        checks++; if ({hso0, r0, g0, b0} !== 10'd0) begin errors++; $display("FAIL pixel_after: got %h want 0", {hso0, r0, g0, b0}); end
    endtask

    task automatic test_scaled();
        logic [8:0] e;
        do_write(0, 1 * 128 + 2, 4'd7);
        show(1'b1, 3, 5);
        checks++; if ({r1, g1, b1} !== 9'b000_111_111) begin errors++; $display("FAIL scaled_3_5: got %h want 03f", {r1, g1, b1}); end
        e = model_rgb(1'b1, 3, 5, 0);
        checks++; if ({r0, g0, b0} !== e) begin errors++; $display("FAIL unscaled_3_5: got %h want %h", {r0, g0, b0}, e); end
        show(1'b1, 256, 0);
        checks++; if ({r1, g1, b1} !== BORDER) begin errors++; $display("FAIL scaled_border: got %h want %h", {r1, g1, b1}, BORDER); end
        checks++; if ({r0, g0, b0} !== BORDER) begin errors++; $display("FAIL unscaled_border: got %h want %h", {r0, g0, b0}, BORDER); end
        show(1'b1, 255, 255);
        e = model_rgb(1'b1, 255, 255, 1);
        checks++; if ({r1, g1, b1} !== e) begin errors++; $display("FAIL scaled_corner: got %h want %h", {r1, g1, b1}, e); end
        show(1'b1, 0, 128);
        checks++; if ({r0, g0, b0} !== BORDER) begin errors++; $display("FAIL unscaled_col_edge: got %h want %h", {r0, g0, b0}, BORDER); end
        show(1'b0, 3, 5);
        checks++; if ({r0, g0, b0, r1, g1, b1} !== 18'd0) begin errors++; $display("FAIL inactive_black: got %h want 0", {r0, g0, b0, r1, g1, b1}); end
    endtask

    task automatic test_auto_ptr();
        pload = 1; waddr = 14'd16383;
        tick();
        pload = 0; ptrm = 16383;
        do_write(1'b1, 0, 4'd8);
        do_write(1'b1, 0, 4'd4);
        do_write(1'b1, 0, 4'd2);
        pload = 1; waddr = 14'd500; wv = 1; wauto = 1; wdata = 4'd6;
        tick();
        pload = 0; wv = 0; wauto = 0;
        fbm[ptrm] = 4'd6; ptrm = 500;
        do_write(1'b1, 0, 4'd10);
        show(1'b1, 127, 127);
        checks++; if ({r0, g0, b0} !== 9'b111_000_000) begin errors++; $display("FAIL ptr_16383: got %h want 1c0", {r0, g0, b0}); end
        show(1'b1, 0, 0);
        checks++; if ({r0, g0, b0} !== 9'b000_111_000) begin errors++; $display("FAIL ptr_wrap0: got %h want 038", {r0, g0, b0}); end
        show(1'b1, 0, 1);
        checks++; if ({r0, g0, b0} !== 9'b000_000_111) begin errors++; $display("FAIL ptr_1: got %h want 007", {r0, g0, b0}); end
        show(1'b1, 0, 2);
        checks++; if ({r0, g0, b0} !== 9'b000_111_111) begin errors++; $display("FAIL ptr_load_coincident_old: got %h want 03f", {r0, g0, b0}); end
        show(1'b1, 3, 116);
        checks++; if ({r0, g0, b0} !== 9'b111_000_111) begin errors++; $display("FAIL ptr_load_coincident_new: got %h want 1c7", {r0, g0, b0}); end
        act = 0;
    endtask

    task automatic test_random_stream();
        localparam int NS = 400;
        logic [8:0] q0[$], q1[$];
        logic [1:0] qs[$];
        logic [8:0] e0, e1;
        logic [1:0] es;
        logic       a;
        int         r, c, wa;
        for (int k = 0; k < NS + 2; k++) begin
            if (k >= 2) begin
                e0 = q0.pop_front(); e1 = q1.pop_front(); es = qs.pop_front();
                checks++; if ({r0, g0, b0} !== e0) begin errors++; $display("FAIL stream_rgb c%0d: got %h want %h", k - 2, {r0, g0, b0}, e0); end
                checks++; if ({r1, g1, b1} !== e1) begin errors++; $display("FAIL stream_rgb_scaled c%0d: got %h want %h", k - 2, {r1, g1, b1}, e1); end
                checks++; if ({hso0, vso0} !== es) begin errors++; $display("FAIL stream_sync c%0d: got %b want %b", k - 2, {hso0, vso0}, es); end
            end
            if (k < NS) begin
                a = ($urandom_range(0, 9) != 0);
                r = ($urandom_range(0, 7) == 0) ? int'($urandom_range(120, 135)) : int'($urandom_range(0, 15));
                c = int'($urandom_range(0, 135));
                act = a; row = 10'(r); col = 10'(c);
                hs = 1'($urandom_range(0, 1)); vs = 1'($urandom_range(0, 1));
                wv = 1'($urandom_range(0, 1)); wauto = 0;
                wa = int'($urandom_range(0, 15)) * 128 + int'($urandom_range(0, 127));
                if (r < 128 && c < 128 && $urandom_range(0, 3) == 0) wa = r * 128 + c;
                waddr = 14'(wa); wdata = 4'($urandom);
                pwe = ($urandom_range(0, 7) == 0); pidx = 4'($urandom); pdata = 9'($urandom);
                if (pwe) palm[pidx] = pdata;
                q0.push_back(model_rgb(a, r, c, 0));
                q1.push_back(model_rgb(a, r, c, 1));
                qs.push_back({hs, vs});
                if (wv) fbm[wa] = wdata;
            end else begin
                idle_inputs();
            end
            tick();
        end
    endtask

    task automatic test_palette_live();
        pal_write(3, 9'b000_000_111);
        do_write(1'b0, 3 * 128 + 3, 4'd3);
        act = 1; row = 10'd3; col = 10'd3;
        tick();
        tick();
        checks++; if ({r0, g0, b0} !== 9'b000_000_111) begin errors++; $display("FAIL pal_before: got %h want 007", {r0, g0, b0}); end
        pwe = 1; pidx = 4'd3; pdata = 9'b111_000_000;
        tick();
        pwe = 0; palm[3] = 9'b111_000_000;
        checks++; if (r0 !== 3'd0) begin errors++; $display("FAIL pal_write_edge: red got %0d want 0", r0); end
        tick();
        checks++; if ({r0, g0, b0} !== 9'b111_000_000) begin errors++; $display("FAIL pal_after: got %h want 1c0", {r0, g0, b0}); end
        act = 0;
    endtask

    task automatic test_reset_mid_clear();
        pal_write(5, 9'b101_101_101);
        clr = 1;
        tick();
        clr = 0;
        repeat (50) tick();
        checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL midclear_busy: got %b want 1", busy0); end
        rst = 1;
        tick();
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL midclear_reset_busy: got %b want 0", busy0); end
        checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL midclear_reset_ready: got %b want 0", rdy0); end
        tick();
        rst = 0;
        tick();
        checks++; if (rdy0 !== 1'b1 || busy0 !== 1'b0) begin errors++; $display("FAIL midclear_release: ready %b busy %b want 1 0", rdy0, busy0); end
        model_reset();
        do_write(1'b0, 70 * 128 + 40, 4'd5);
        show(1'b1, 70, 40);
        checks++; if ({r0, g0, b0} !== 9'b000_111_000) begin errors++; $display("FAIL pal_default5: got %h want 038", {r0, g0, b0}); end
        do_write(1'b1, 0, 4'd6);
        show(1'b1, 0, 0);
        checks++; if ({r0, g0, b0} !== 9'b000_111_111) begin errors++; $display("FAIL ptr_after_reset: got %h want 03f", {r0, g0, b0}); end
        act = 0;
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        test_reset();
        test_clear();
        test_readback_all();
        test_pixel_basic();
        test_scaled();
        test_auto_ptr();
        test_random_stream();
        test_palette_live();
        test_reset_mid_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
